// File: rtl/jk_pkg.sv
// Shared types and J/K excitation rule for the JK bank controller.
// Pure declarations: no latency, no flow control.
// A don't-care in the JK table is resolved by policy: separate set/reset, or toggle.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_e;

    localparam int POL_SETRST = 0;
    localparam int POL_TOGGLE = 1;

    // Returns {J,K} that moves a JK flop from q to d in one clock.
    function automatic logic [1:0] jk_excite(input logic q, input logic d, input int policy);
        logic [1:0] jk;
        jk = 2'b00;
        if (q != d) begin
            if (policy == POL_TOGGLE) begin
                jk = 2'b11;
            end else begin
                jk = d ? 2'b10 : 2'b01;
            end
        end
        return jk;
    endfunction

endpackage

// File: rtl/jk_excite_bit.sv
// Per-bit J/K excitation from current Q and desired next state.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module jk_excite_bit
    import jk_pkg::*;
#(
    parameter int POLICY = POL_SETRST
) (
    input  logic q,
    input  logic d,
    output logic j,
    output logic k
);

    assign {j, k} = jk_excite(q, d, POLICY);

endmodule

// File: rtl/jk_excite_ctrl.sv
// Drives an external JK bank toward a requested state, verifying and retrying.
// Latency: accept at edge 0, done/err in cycle 3; each retry adds 2 cycles.
// Backpressure: tgt_ready low in DRIVE/CHECK; a new target may be accepted in the done/err cycle.
module jk_excite_ctrl
    import jk_pkg::*;
#(
    parameter  int WIDTH     = 4,
    parameter  int MAX_RETRY = 3,
    parameter  int DC_POLICY = POL_SETRST,
    localparam int RW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [RW-1:0]    retries
);

    state_e           state;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] exc_d;
    logic [WIDTH-1:0] exc_j;
    logic [WIDTH-1:0] exc_k;

    // In IDLE the excitation aims at the incoming request; in CHECK at the held target.
    assign exc_d = (state == IDLE) ? tgt_data : target;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_excite_bit #(
            .POLICY(DC_POLICY)
        ) u_bit (
            .q(q_fb[i]),
            .d(exc_d[i]),
            .j(exc_j[i]),
            .k(exc_k[i])
        );
    end

    assign tgt_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            target  <= '0;
            j       <= '0;
            k       <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            retries <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (tgt_valid) begin
                        target  <= tgt_data;
                        retries <= '0;
                        j       <= exc_j;
                        k       <= exc_k;
                        state   <= DRIVE;
                    end
                end
                DRIVE: begin
                    j     <= '0;
                    k     <= '0;
                    state <= CHECK;
                end
                CHECK: begin
                    if (q_fb == target) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (retries < RW'(MAX_RETRY)) begin
                        retries <= retries + RW'(1);
                        j       <= exc_j;
                        k       <= exc_k;
                        state   <= DRIVE;
                    end else begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    j     <= '0;
                    k     <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_excite_ctrl.sv
// Closed-loop bench: two controllers (set/reset and toggle policy) each drive a behavioural 4-bit JK bank.
module tb_jk_excite_ctrl;

    logic       clk;
    logic       rst;
    logic       tv     [2];
    logic [3:0] td     [2];
    logic       rdy    [2];
    logic [3:0] jo     [2];
    logic [3:0] ko     [2];
    logic       busy_o [2];
    logic       done_o [2];
    logic       err_o  [2];
    logic [1:0] ret_o  [2];
    logic [3:0] bank   [2];
    logic [3:0] stuck  [2];
    logic       load   [2];
    logic [3:0] init_v [2];
    logic       mon_en;

    int total;
    int bad;

    typedef struct {
        int         pol;
        logic [3:0] init;
        logic [3:0] tgt;
        logic [3:0] ej;
        logic [3:0] ek;
    } vec_t;

    vec_t vecs [7];

    jk_excite_ctrl #(.WIDTH(4), .MAX_RETRY(3), .DC_POLICY(0)) u_dut0 (
        .clk(clk), .rst(rst), .tgt_valid(tv[0]), .tgt_ready(rdy[0]), .tgt_data(td[0]),
        .q_fb(bank[0]), .j(jo[0]), .k(ko[0]), .busy(busy_o[0]), .done(done_o[0]),
        .err(err_o[0]), .retries(ret_o[0])
    );

    jk_excite_ctrl #(.WIDTH(4), .MAX_RETRY(3), .DC_POLICY(1)) u_dut1 (
        .clk(clk), .rst(rst), .tgt_valid(tv[1]), .tgt_ready(rdy[1]), .tgt_data(td[1]),
        .q_fb(bank[1]), .j(jo[1]), .k(ko[1]), .busy(busy_o[1]), .done(done_o[1]),
        .err(err_o[1]), .retries(ret_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural JK bank; a stuck bit is held at 0 regardless of drive.
    always @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (load[p]) begin
                bank[p] <= init_v[p];
            end else begin
                for (int i = 0; i < 4; i++) begin
                    case ({jo[p][i], ko[p][i]})
                        2'b10:   bank[p][i] <= 1'b1;
                        2'b01:   bank[p][i] <= 1'b0;
                        2'b11:   bank[p][i] <= ~bank[p][i];
                        default: ;
                    endcase
                    if (stuck[p][i]) bank[p][i] <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("jk_not_both_pol0", 32'(jo[0] & ko[0]), 32'h0);
            chk("done_err_excl0", 32'(done_o[0] & err_o[0]), 32'h0);
            chk("done_err_excl1", 32'(done_o[1] & err_o[1]), 32'h0);
        end
    end

    task automatic load_bank(input int p, input logic [3:0] v);
        load[p]   = 1'b1;
        init_v[p] = v;
        @(negedge clk);
        load[p]   = 1'b0;
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int p;
        p = v.pol;
        load_bank(p, v.init);
        chk($sformatf("v%0d_ready_idle", n), 32'(rdy[p]), 32'h1);
        tv[p] = 1'b1;
        td[p] = v.tgt;
        @(negedge clk);
        tv[p] = 1'b0;
        chk($sformatf("v%0d_j_drive", n), 32'(jo[p]), 32'(v.ej));
        chk($sformatf("v%0d_k_drive", n), 32'(ko[p]), 32'(v.ek));
        chk($sformatf("v%0d_ready_drive", n), 32'(rdy[p]), 32'h0);
        chk($sformatf("v%0d_busy_drive", n), 32'(busy_o[p]), 32'h1);
        chk($sformatf("v%0d_done_drive", n), 32'(done_o[p] | err_o[p]), 32'h0);
        @(negedge clk);
        chk($sformatf("v%0d_jk_check", n), 32'({jo[p], ko[p]}), 32'h0);
        chk($sformatf("v%0d_q_check", n), 32'(bank[p]), 32'(v.tgt));
        chk($sformatf("v%0d_done_check", n), 32'(done_o[p]), 32'h0);
        @(negedge clk);
        chk($sformatf("v%0d_done", n), 32'(done_o[p]), 32'h1);
        chk($sformatf("v%0d_err", n), 32'(err_o[p]), 32'h0);
        chk($sformatf("v%0d_ready_done", n), 32'(rdy[p]), 32'h1);
        chk($sformatf("v%0d_retries", n), 32'(ret_o[p]), 32'h0);
        @(negedge clk);
        chk($sformatf("v%0d_done_clear", n), 32'(done_o[p]), 32'h0);
    endtask

    initial begin
        int drives;
        int saw_done;
        total  = 0;
        bad    = 0;
        mon_en = 1'b0;
        rst    = 1'b1;
        for (int p = 0; p < 2; p++) begin
            tv[p] = 1'b0; td[p] = 4'h0; stuck[p] = 4'h0; load[p] = 1'b1; init_v[p] = 4'h0;
        end

        vecs[0] = '{0, 4'b0000, 4'b1010, 4'b1010, 4'b0000};
        vecs[1] = '{0, 4'b1111, 4'b0101, 4'b0000, 4'b1010};
        vecs[2] = '{0, 4'b1001, 4'b0011, 4'b0010, 4'b1000};
        vecs[3] = '{0, 4'b0110, 4'b0110, 4'b0000, 4'b0000};
        vecs[4] = '{1, 4'b1100, 4'b0110, 4'b1010, 4'b1010};
        vecs[5] = '{1, 4'b0101, 4'b0101, 4'b0000, 4'b0000};
        vecs[6] = '{1, 4'b0000, 4'b1111, 4'b1111, 4'b1111};

        repeat (2) @(negedge clk);
        chk("rst_j", 32'(jo[0]), 32'h0);
        chk("rst_k", 32'(ko[0]), 32'h0);
        chk("rst_busy", 32'(busy_o[0]), 32'h0);
        chk("rst_done_err", 32'({done_o[0], err_o[0]}), 32'h0);
        chk("rst_retries", 32'(ret_o[0]), 32'h0);
        chk("rst_ready", 32'(rdy[0]), 32'h1);
        load[0] = 1'b0;
        load[1] = 1'b0;
        rst     = 1'b0;
        mon_en  = 1'b1;
        @(negedge clk);

        for (int n = 0; n < 7; n++) run_vec(n, vecs[n]);

        // Retry then success: bit0 ignores the first drive only.
        load_bank(0, 4'b0000);
        stuck[0] = 4'b0001;
        tv[0] = 1'b1; td[0] = 4'b0001;
        @(negedge clk);
        tv[0] = 1'b0;
        chk("retry_j1", 32'(jo[0]), 32'h1);
        @(negedge clk);
        chk("retry_q_stuck", 32'(bank[0]), 32'h0);
        chk("retry_no_done2", 32'(done_o[0] | err_o[0]), 32'h0);
        stuck[0] = 4'b0000;
        @(negedge clk);
        chk("retry_j2", 32'(jo[0]), 32'h1);
        chk("retry_k2", 32'(ko[0]), 32'h0);
        chk("retry_cnt3", 32'(ret_o[0]), 32'h1);
        @(negedge clk);
        chk("retry_no_done4", 32'(done_o[0]), 32'h0);
        @(negedge clk);
        chk("retry_done5", 32'(done_o[0]), 32'h1);
        chk("retry_err5", 32'(err_o[0]), 32'h0);
        chk("retry_cnt5", 32'(ret_o[0]), 32'h1);
        chk("retry_q5", 32'(bank[0]), 32'h1);
        @(negedge clk);

        // Exhausted retries: bit0 permanently stuck.
        load_bank(0, 4'b0000);
        stuck[0] = 4'b0001;
        tv[0] = 1'b1; td[0] = 4'b0001;
        drives = 0;
        saw_done = 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            tv[0] = 1'b0;
            if (jo[0] == 4'b0001) drives++;
            if (done_o[0]) saw_done++;
            if (c < 9) chk($sformatf("exh_no_err_c%0d", c), 32'(err_o[0]), 32'h0);
        end
        chk("exh_err9", 32'(err_o[0]), 32'h1);
        chk("exh_drives", 32'(drives), 32'd4);
        chk("exh_no_done", 32'(saw_done), 32'd0);
        chk("exh_retries", 32'(ret_o[0]), 32'd3);
        chk("exh_ready9", 32'(rdy[0]), 32'h1);
        @(negedge clk);
        chk("exh_err_clear", 32'(err_o[0]), 32'h0);
        chk("exh_retries_hold", 32'(ret_o[0]), 32'd3);
        stuck[0] = 4'b0000;

        // Handshake: valid held, data changes while busy, second accept in done cycle.
        load_bank(0, 4'b0000);
        tv[0] = 1'b1; td[0] = 4'b0011;
        @(negedge clk);
        td[0] = 4'b1111;
        chk("hs_ready_drive", 32'(rdy[0]), 32'h0);
        chk("hs_j_drive", 32'(jo[0]), 32'b0011);
        @(negedge clk);
        tv[0] = 1'b0;
        chk("hs_ready_check", 32'(rdy[0]), 32'h0);
        @(negedge clk);
        tv[0] = 1'b1; td[0] = 4'b0100;
        chk("hs_done1", 32'(done_o[0]), 32'h1);
        chk("hs_q1", 32'(bank[0]), 32'b0011);
        chk("hs_ready_done", 32'(rdy[0]), 32'h1);
        @(negedge clk);
        tv[0] = 1'b0;
        chk("hs_j2", 32'(jo[0]), 32'b0100);
        chk("hs_k2", 32'(ko[0]), 32'b0011);
        chk("hs_busy2", 32'(busy_o[0]), 32'h1);
        @(negedge clk);
        @(negedge clk);
        chk("hs_done2", 32'(done_o[0]), 32'h1);
        chk("hs_q2", 32'(bank[0]), 32'b0100);
        @(negedge clk);

        // Reset during DRIVE.
        load_bank(0, 4'b0000);
        tv[0] = 1'b1; td[0] = 4'b0101;
        @(negedge clk);
        tv[0] = 1'b0;
        chk("rm_j_drive", 32'(jo[0]), 32'b0101);
        rst = 1'b1;
        #1;
        chk("rm_j", 32'(jo[0]), 32'h0);
        chk("rm_k", 32'(ko[0]), 32'h0);
        chk("rm_ready", 32'(rdy[0]), 32'h1);
        chk("rm_busy", 32'(busy_o[0]), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done_o[0] | err_o[0]) saw_done++;
        end
        chk("rm_no_pulse", 32'(saw_done), 32'd0);
        chk("rm_bank_held", 32'(bank[0]), 32'h0);
        tv[0] = 1'b1; td[0] = 4'b1111;
        @(negedge clk);
        tv[0] = 1'b0;
        chk("rm_new_j", 32'(jo[0]), 32'b1111);
        @(negedge clk);
        @(negedge clk);
        chk("rm_new_done", 32'(done_o[0]), 32'h1);
        chk("rm_new_q", 32'(bank[0]), 32'b1111);
        chk("rm_new_retries", 32'(ret_o[0]), 32'h0);
        @(negedge clk);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
